// File: rtl/half_div_ctrl_pkg.sv
// half_div_pkg: shared types and constants for the N/2 clock divider slice.
//   hdc_state_e   : controller sequencer states
//   MIN_DIV2      : smallest legal 2x ratio (divide by 1.5)
//   MIN_HI_HALVES : shortest high time, in half clk cycles, that the OR of a
//                   posedge register and a negedge register can produce
package half_div_pkg;

   typedef enum logic [1:0] {OFF, RUN, STOPPING} hdc_state_e;

   localparam int MIN_DIV2      = 3;
   localparam int MIN_HI_HALVES = 2;

endpackage

// File: rtl/half_div_ctrl_if.sv
// half_div_ctrl_if: ratio-request handshake between the config block (master)
// and the divider controller (slave).
//   cfg_valid : request present
//   cfg_div2  : requested 2x ratio, held stable while cfg_valid is high
//   cfg_ready : request taken on a posedge where cfg_valid & cfg_ready
//   cfg_err   : one-cycle pulse after an illegal (< MIN_DIV2) request is taken
interface half_div_ctrl_if #(
   parameter int W = 5
);
   logic         cfg_valid;
   logic [W-1:0] cfg_div2;
   logic         cfg_ready;
   logic         cfg_err;

   modport master (output cfg_valid, cfg_div2, input  cfg_ready, cfg_err);
   modport slave  (input  cfg_valid, cfg_div2, output cfg_ready, cfg_err);
endinterface

// File: rtl/half_div_ctrl_core.sv
// half_div_core: frame counter and glitch-free output stage of the divider.
//   clk, rstn  : source clock, async active-low reset
//   div2       : 2x ratio; must only change while cnt == 0
//   run        : count and produce edges (controller in RUN)
//   clk_out    : divided clock = pos_q | neg_q
//   wrap       : last cycle of a running frame (cnt == div2-1)
//   frame_tick : first cycle of a running frame (cnt == 0)
//
// A frame is div2 clk cycles = 2*div2 half-cycles and holds two output
// periods. Pulse A starts at half 0, pulse B at half div2; both last
// hi = div2>>1 half-cycles. The output is built from 2-half-cycle segments:
// the segment starting at an even half comes from pos_q, the one at an odd
// half from neg_q. A segment is on when it lies fully inside a pulse, so the
// union of on-segments is exactly the pulse and every output edge is caused by
// one register changing on its own clock edge.
//
// pos_q and neg_set decode cnt at the posedge that ends the cycle, so the
// waveform trails cnt by one clk. neg_set is re-timed to the negedge, which
// places the odd segment half a cycle after its even neighbour. This lag is
// what the controller's STOPPING cycle plays out.
module half_div_core
   import half_div_pkg::*;
#(
   parameter int W = 5
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic [W-1:0] div2,
   input  logic         run,
   output logic         clk_out,
   output logic         wrap,
   output logic         frame_tick
);

   localparam int TW = W + 2;
   localparam logic [TW-1:0] MIN_HI = TW'(MIN_HI_HALVES);

   logic [W-1:0]  cnt;
   logic          pos_q, neg_set, neg_q;
   logic          pos_on, neg_on;
   logic [TW-1:0] hi, t_pos, t_neg, a_last, b_beg, b_last;

   assign wrap       = run && (cnt == div2 - 1'b1);
   assign frame_tick = run && (cnt == '0);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)              cnt <= '0;
      else if (!run || wrap)  cnt <= '0;
      else                    cnt <= cnt + 1'b1;
   end

   // Segment decode. div2 = 3 would want a 0.5 clk pulse, which a pair of
   // OR'd full-cycle registers cannot make; it is widened to 1 clk.
   always_comb begin
      hi = TW'(div2 >> 1);
      if (hi < MIN_HI) hi = MIN_HI;
      t_pos  = TW'({cnt, 1'b0});
      t_neg  = t_pos + TW'(1);
      b_beg  = TW'(div2);
      a_last = hi - MIN_HI;           // last segment start inside pulse A
      b_last = b_beg + hi - MIN_HI;   // last segment start inside pulse B
      pos_on = run && ((t_pos <= a_last) || ((t_pos >= b_beg) && (t_pos <= b_last)));
      neg_on = run && ((t_neg <= a_last) || ((t_neg >= b_beg) && (t_neg <= b_last)));
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         pos_q   <= 1'b0;
         neg_set <= 1'b0;
      end else begin
         pos_q   <= pos_on;
         neg_set <= neg_on;
      end
   end

   always_ff @(negedge clk or negedge rstn) begin
      if (!rstn) neg_q <= 1'b0;
      else       neg_q <= neg_set;
   end

   assign clk_out = pos_q | neg_q;

endmodule

// File: rtl/half_div_ctrl.sv
// half_div_ctrl: programmable N/2 clock divider controller.
//   clk, rstn  : source clock, async active-low reset
//   en         : level; 1 = run, 0 = stop at the end of the current frame
//   cfg        : ratio request handshake (slave side)
//   cur_div2   : 2x ratio currently driving the core
//   clk_out    : divided clock
//   active     : controller in RUN
//   frame_tick : one-cycle pulse on the first cycle of each running frame
//
// A one-entry staging register (pend/pend_div2) holds an accepted ratio until
// it can be applied safely: immediately while OFF, otherwise at a frame wrap
// so cur_div2 only ever changes while the core counter sits at 0.
module half_div_ctrl
   import half_div_pkg::*;
#(
   parameter int W        = 5,
   parameter int DEF_DIV2 = 7
) (
   input  logic           clk,
   input  logic           rstn,
   input  logic           en,
   half_div_ctrl_if.slave cfg,
   output logic [W-1:0]   cur_div2,
   output logic           clk_out,
   output logic           active,
   output logic           frame_tick
);

   hdc_state_e   state, state_nxt;
   logic         pend;
   logic [W-1:0] pend_div2;
   logic         err_q;
   logic         run, wrap;
   logic         accept, legal, load;

   assign run    = (state == RUN);
   assign active = run;

   // No new request while one is staged or while the stop is draining.
   assign cfg.cfg_ready = !pend && (state != STOPPING);
   assign cfg.cfg_err   = err_q;
   assign accept        = cfg.cfg_valid && cfg.cfg_ready;
   assign legal         = (cfg.cfg_div2 >= W'(MIN_DIV2));

   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      case (state)
         OFF: begin
            load = pend;
            if (en) state_nxt = RUN;
         end
         RUN: begin
            // en is only looked at on the wrap, so a drop and re-assert
            // inside one frame never stops the clock.
            if (wrap) begin
               load = pend;
               if (!en) state_nxt = STOPPING;
            end
         end
         STOPPING: state_nxt = OFF;
         default:  state_nxt = OFF;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= OFF;
      else       state <= state_nxt;
   end

   // load needs pend=1 and accept needs pend=0, so they never collide; a
   // request accepted on a wrap cycle therefore waits for the next wrap.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         pend      <= 1'b0;
         pend_div2 <= '0;
         cur_div2  <= W'(DEF_DIV2);
         err_q     <= 1'b0;
      end else begin
         err_q <= accept && !legal;
         if (load) begin
            cur_div2 <= pend_div2;
            pend     <= 1'b0;
         end
         if (accept && legal) begin
            pend      <= 1'b1;
            pend_div2 <= cfg.cfg_div2;
         end
      end
   end

   half_div_core #(.W(W)) u_core (
      .clk        (clk),
      .rstn       (rstn),
      .div2       (cur_div2),
      .run        (run),
      .clk_out    (clk_out),
      .wrap       (wrap),
      .frame_tick (frame_tick)
   );

endmodule

// File: tb/tb_half_div_ctrl.sv
// Directed bench for half_div_ctrl. clk_out is sampled every half cycle into
// hist[]; waveform half 0 of a frame is the posedge after its frame_tick cycle.
module tb_half_div_ctrl;

   localparam int W = 5;
   localparam int HMAX = 4096;

   logic         clk = 1'b0;
   logic         rstn;
   logic         en;
   logic [W-1:0] cur_div2;
   logic         clk_out, active, frame_tick;

   int checks = 0;
   int fails  = 0;
   int hc     = 0;
   logic hist [0:HMAX-1];

   half_div_ctrl_if #(.W(W)) cif ();

   half_div_ctrl #(.W(W), .DEF_DIV2(7)) dut (
      .clk        (clk),
      .rstn       (rstn),
      .en         (en),
      .cfg        (cif),
      .cur_div2   (cur_div2),
      .clk_out    (clk_out),
      .active     (active),
      .frame_tick (frame_tick)
   );

   always #5 clk = ~clk;

   always begin
      @(posedge clk); #1;
      if (hc < HMAX) hist[hc] = clk_out;
      hc++;
      @(negedge clk); #1;
      if (hc < HMAX) hist[hc] = clk_out;
      hc++;
   end

   task automatic step();
      @(posedge clk); #2;
   endtask

   // Steps until frame_tick is seen; n = cycles taken (64 on timeout).
   task automatic wait_tick(output int n);
      n = 0;
      do begin
         step();
         n++;
      end while (!frame_tick && n < 64);
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #2;
      checks++; if (clk_out !== 1'b0) begin fails++; $display("FAIL rst_clk_out: got %b want 0", clk_out); end
      checks++; if (active !== 1'b0) begin fails++; $display("FAIL rst_active: got %b want 0", active); end
      checks++; if (frame_tick !== 1'b0) begin fails++; $display("FAIL rst_tick: got %b want 0", frame_tick); end
      checks++; if (cif.cfg_err !== 1'b0) begin fails++; $display("FAIL rst_err: got %b want 0", cif.cfg_err); end
      checks++; if (cur_div2 !== 5'd7) begin fails++; $display("FAIL rst_div2: got %0d want 7", cur_div2); end
      rstn = 1'b1;
      step();
      checks++; if (cif.cfg_ready !== 1'b1) begin fails++; $display("FAIL rst_ready: got %b want 1", cif.cfg_ready); end
      checks++; if (active !== 1'b0) begin fails++; $display("FAIL rst_off_active: got %b want 0", active); end
   endtask

   task automatic test_run_default();
      int n, base;
      logic [13:0] g;
      en = 1'b1;
      wait_tick(n);
      checks++; if (n !== 1) begin fails++; $display("FAIL t1_start: got %0d want 1", n); end
      base = hc + 1;
      checks++; if (active !== 1'b1) begin fails++; $display("FAIL t1_active: got %b want 1", active); end
      checks++; if (cur_div2 !== 5'd7) begin fails++; $display("FAIL t1_div2: got %0d want 7", cur_div2); end
      wait_tick(n);
      checks++; if (n !== 7) begin fails++; $display("FAIL t1_frame: got %0d want 7", n); end
      step();
      for (int i = 0; i < 14; i++) g[i] = hist[base+i];
      checks++; if (g !== 14'b00001110000111) begin fails++; $display("FAIL t1_wave: got %b want %b", g, 14'b00001110000111); end
   endtask

   task automatic test_reconfig();
      int n, base, base2;
      logic [13:0] g7;
      logic [7:0]  g4;
      wait_tick(n);
      checks++; if (n !== 6) begin fails++; $display("FAIL t2_sync: got %0d want 6", n); end
      base = hc + 1;
      step(); step();                       // cnt = 2
      cif.cfg_valid = 1'b1; cif.cfg_div2 = 5'd4;
      checks++; if (cif.cfg_ready !== 1'b1) begin fails++; $display("FAIL t2_ready: got %b want 1", cif.cfg_ready); end
      step();
      cif.cfg_valid = 1'b0;
      checks++; if (cif.cfg_ready !== 1'b0) begin fails++; $display("FAIL t2_pend: got %b want 0", cif.cfg_ready); end
      checks++; if (cur_div2 !== 5'd7) begin fails++; $display("FAIL t2_hold: got %0d want 7", cur_div2); end
      wait_tick(n);
      checks++; if (n !== 4) begin fails++; $display("FAIL t2_rest: got %0d want 4", n); end
      checks++; if (cur_div2 !== 5'd4) begin fails++; $display("FAIL t2_apply: got %0d want 4", cur_div2); end
      base2 = hc + 1;
      checks++; if (base2 - base !== 14) begin fails++; $display("FAIL t2_len: got %0d want 14", base2 - base); end
      wait_tick(n);
      checks++; if (n !== 4) begin fails++; $display("FAIL t2_frame4: got %0d want 4", n); end
      step();
      for (int i = 0; i < 14; i++) g7[i] = hist[base+i];
      for (int i = 0; i < 8; i++)  g4[i] = hist[base2+i];
      checks++; if (g7 !== 14'b00001110000111) begin fails++; $display("FAIL t2_wave7: got %b want %b", g7, 14'b00001110000111); end
      checks++; if (g4 !== 8'b00110011) begin fails++; $display("FAIL t2_wave4: got %b want %b", g4, 8'b00110011); end
   endtask

   task automatic test_cfg_err();
      int n;
      cif.cfg_valid = 1'b1; cif.cfg_div2 = 5'd2;   // cnt = 1, div2 = 4
      checks++; if (cif.cfg_ready !== 1'b1) begin fails++; $display("FAIL t3_ready: got %b want 1", cif.cfg_ready); end
      step();
      cif.cfg_valid = 1'b0;
      checks++; if (cif.cfg_err !== 1'b1) begin fails++; $display("FAIL t3_err: got %b want 1", cif.cfg_err); end
      checks++; if (cif.cfg_ready !== 1'b1) begin fails++; $display("FAIL t3_ready_after: got %b want 1", cif.cfg_ready); end
      checks++; if (cur_div2 !== 5'd4) begin fails++; $display("FAIL t3_div2: got %0d want 4", cur_div2); end
      step();                                        // cnt = 3 (wrap cycle)
      checks++; if (cif.cfg_err !== 1'b0) begin fails++; $display("FAIL t3_err_pulse: got %b want 0", cif.cfg_err); end
      cif.cfg_valid = 1'b1; cif.cfg_div2 = 5'd3;     // accepted on the wrap
      step();
      cif.cfg_valid = 1'b0;
      checks++; if (cif.cfg_err !== 1'b0) begin fails++; $display("FAIL t3_min_err: got %b want 0", cif.cfg_err); end
      checks++; if (frame_tick !== 1'b1) begin fails++; $display("FAIL t3_wrap_tick: got %b want 1", frame_tick); end
      checks++; if (cur_div2 !== 5'd4) begin fails++; $display("FAIL t3_not_yet: got %0d want 4", cur_div2); end
      wait_tick(n);
      checks++; if (n !== 4) begin fails++; $display("FAIL t3_frame: got %0d want 4", n); end
      checks++; if (cur_div2 !== 5'd3) begin fails++; $display("FAIL t3_min_apply: got %0d want 3", cur_div2); end
      wait_tick(n);
      checks++; if (n !== 3) begin fails++; $display("FAIL t3_frame3: got %0d want 3", n); end
   endtask

   task automatic test_back_to_back();
      int n, base;
      logic [17:0] g;
      cif.cfg_valid = 1'b1; cif.cfg_div2 = 5'd9;   // cnt = 0, div2 = 3
      checks++; if (cif.cfg_ready !== 1'b1) begin fails++; $display("FAIL t4_ready9: got %b want 1", cif.cfg_ready); end
      step();
      cif.cfg_div2 = 5'd5;
      checks++; if (cif.cfg_ready !== 1'b0) begin fails++; $display("FAIL t4_stall: got %b want 0", cif.cfg_ready); end
      n = 0;
      while (!cif.cfg_ready && n < 64) begin step(); n++; end
      checks++; if (n !== 2) begin fails++; $display("FAIL t4_stall_len: got %0d want 2", n); end
      checks++; if (cur_div2 !== 5'd9) begin fails++; $display("FAIL t4_apply9: got %0d want 9", cur_div2); end
      checks++; if (frame_tick !== 1'b1) begin fails++; $display("FAIL t4_tick: got %b want 1", frame_tick); end
      base = hc + 1;
      step();
      cif.cfg_valid = 1'b0;
      checks++; if (cif.cfg_ready !== 1'b0) begin fails++; $display("FAIL t4_pend5: got %b want 0", cif.cfg_ready); end
      wait_tick(n);
      checks++; if (n !== 8) begin fails++; $display("FAIL t4_frame9: got %0d want 8", n); end
      checks++; if (cur_div2 !== 5'd5) begin fails++; $display("FAIL t4_apply5: got %0d want 5", cur_div2); end
      step();
      for (int i = 0; i < 18; i++) g[i] = hist[base+i];
      checks++; if (g !== 18'b000001111000001111) begin fails++; $display("FAIL t4_wave9: got %b want %b", g, 18'b000001111000001111); end
   endtask

   task automatic test_stop_start();
      int n, base;
      logic [13:0] g;
      logic [5:0]  z;
      cif.cfg_valid = 1'b1; cif.cfg_div2 = 5'd7;   // cnt = 1, div2 = 5
      step();
      cif.cfg_valid = 1'b0;
      wait_tick(n);
      checks++; if (cur_div2 !== 5'd7) begin fails++; $display("FAIL t5_div2: got %0d want 7", cur_div2); end
      // en drop and re-assert inside one frame: no stop
      step(); en = 1'b0;
      step(); step(); en = 1'b1;
      wait_tick(n);
      checks++; if (n !== 4) begin fails++; $display("FAIL t5_cont: got %0d want 4", n); end
      checks++; if (active !== 1'b1) begin fails++; $display("FAIL t5_cont_active: got %b want 1", active); end
      // real stop requested at cnt = 1
      base = hc + 1;
      step(); en = 1'b0;
      repeat (5) step();                             // cnt = 6
      checks++; if (active !== 1'b1) begin fails++; $display("FAIL t5_last_active: got %b want 1", active); end
      step();                                        // STOPPING
      checks++; if (active !== 1'b0) begin fails++; $display("FAIL t5_stopping: got %b want 0", active); end
      checks++; if (frame_tick !== 1'b0) begin fails++; $display("FAIL t5_no_tick: got %b want 0", frame_tick); end
      step();                                        // OFF
      checks++; if (clk_out !== 1'b0) begin fails++; $display("FAIL t5_off_clk: got %b want 0", clk_out); end
      repeat (3) step();
      for (int i = 0; i < 14; i++) g[i] = hist[base+i];
      for (int i = 0; i < 6; i++)  z[i] = hist[base+14+i];
      checks++; if (g !== 14'b00001110000111) begin fails++; $display("FAIL t5_full_frame: got %b want %b", g, 14'b00001110000111); end
      checks++; if (z !== 6'b000000) begin fails++; $display("FAIL t5_quiet: got %b want 000000", z); end
      en = 1'b1;
      step();
      checks++; if (frame_tick !== 1'b1) begin fails++; $display("FAIL t5_restart_tick: got %b want 1", frame_tick); end
      checks++; if (active !== 1'b1) begin fails++; $display("FAIL t5_restart_active: got %b want 1", active); end
   endtask

   task automatic test_async_reset();
      int n;
      cif.cfg_valid = 1'b1; cif.cfg_div2 = 5'd5;   // cnt = 0, div2 = 7
      step();
      cif.cfg_valid = 1'b0;
      wait_tick(n);
      checks++; if (n !== 6) begin fails++; $display("FAIL t6_sync: got %0d want 6", n); end
      checks++; if (cur_div2 !== 5'd5) begin fails++; $display("FAIL t6_div2: got %0d want 5", cur_div2); end
      step();                                        // pulse A high
      checks++; if (clk_out !== 1'b1) begin fails++; $display("FAIL t6_high: got %b want 1", clk_out); end
      #1 rstn = 1'b0;
      #1;
      checks++; if (clk_out !== 1'b0) begin fails++; $display("FAIL t6_async_clk: got %b want 0", clk_out); end
      checks++; if (active !== 1'b0) begin fails++; $display("FAIL t6_async_active: got %b want 0", active); end
      checks++; if (cur_div2 !== 5'd7) begin fails++; $display("FAIL t6_async_div2: got %0d want 7", cur_div2); end
      en = 1'b0;
      @(posedge clk); #2;
      rstn = 1'b1;
      step();
      checks++; if (cur_div2 !== 5'd7) begin fails++; $display("FAIL t6_post_div2: got %0d want 7", cur_div2); end
      checks++; if (clk_out !== 1'b0) begin fails++; $display("FAIL t6_post_clk: got %b want 0", clk_out); end
      checks++; if (active !== 1'b0) begin fails++; $display("FAIL t6_post_active: got %b want 0", active); end
   endtask

   initial begin
      rstn = 1'b0;
      en   = 1'b0;
      cif.cfg_valid = 1'b0;
      cif.cfg_div2  = '0;
      test_reset();
      test_run_default();
      test_reconfig();
      test_cfg_err();
      test_back_to_back();
      test_stop_start();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule
